// File: rtl/hazard_pkg.sv
// Shared defaults and the scoreboard entry type for the decode-stage hazard scoreboard.
package hazard_pkg;

    localparam int REG_W_DEF    = 5;
    localparam int ZERO_REG_DEF = 31;
    // Entries hold dst zero-extended to this width so one typedef serves every REG_W up to 8.
    localparam int REG_W_MAX    = 8;

    typedef struct packed {
        logic                 valid;
        logic [REG_W_MAX-1:0] dst;
    } sb_entry_t;

    function automatic int stage_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the issue logic (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int REG_W   = hazard_pkg::REG_W_DEF,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2
);
    import hazard_pkg::*;

    localparam int STG_W = stage_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                            issue_valid;
    logic                            issue_wr_en;
    logic [REG_W-1:0]                issue_dst;
    logic [NUM_SRC-1:0][REG_W-1:0]   src_addr;
    logic [NUM_SRC-1:0]              src_used;
    logic                            freeze;
    logic                            flush;
    logic [NUM_SRC-1:0]              hazard;
    logic [NUM_SRC-1:0][STG_W-1:0]   match_stage;
    logic                            stall;
    logic [CNT_W-1:0]                pending_count;

    modport master (
        output issue_valid, issue_wr_en, issue_dst, src_addr, src_used, freeze, flush,
        input  hazard, match_stage, stall, pending_count
    );

    modport slave (
        input  issue_valid, issue_wr_en, issue_dst, src_addr, src_used, freeze, flush,
        output hazard, match_stage, stall, pending_count
    );

endinterface

// File: rtl/reg_addr_compare.sv
// Qualified register-address equality: one source port against one tracked writer.
module reg_addr_compare #(
    parameter int W = 5
) (
    input  logic         valid_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         match_o
);

    assign match_o = valid_i && (a_i == b_i);

endmodule

// File: rtl/hazard_scoreboard.sv
// Read-after-write hazard scoreboard: a shift register of in-flight writers checked
// combinationally against the source registers of the instruction in decode.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int DEPTH    = 3,
    parameter int NUM_SRC  = 2,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave sb
);

    localparam int STG_W = stage_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0]          entry_q;
    sb_entry_t [DEPTH-1:0]          entry_d;
    logic [NUM_SRC-1:0]             src_live_s;
    logic [NUM_SRC-1:0][DEPTH-1:0]  hit_s;
    logic [NUM_SRC-1:0]             hazard_s;
    logic [NUM_SRC-1:0][STG_W-1:0]  match_s;
    logic                           stall_s;
    logic [CNT_W-1:0]               count_s;
    logic                           dst_writes_s;

    // A source port is checked only when it is really read and is not the zero register.
    always_comb begin
        src_live_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_live_s[i] = sb.issue_valid && sb.src_used[i]
                            && (sb.src_addr[i] != REG_W'(ZERO_REG));
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            reg_addr_compare #(.W(REG_W_MAX)) u_cmp (
                .valid_i (entry_q[k].valid && src_live_s[i]),
                .a_i     (entry_q[k].dst),
                .b_i     (REG_W_MAX'(sb.src_addr[i])),
                .match_o (hit_s[i][k])
            );
        end
    end

    // Priority encode: scanning old-to-young lets the youngest hit overwrite older ones.
    always_comb begin
        hazard_s = '0;
        match_s  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hazard_s[i] = |hit_s[i];
            for (int k = DEPTH - 1; k >= 0; k--) begin
                match_s[i] = hit_s[i][k] ? STG_W'(k) : match_s[i];
            end
        end
        stall_s = |hazard_s;
    end

    // Number of valid tracked writers.
    always_comb begin
        count_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_s = count_s + CNT_W'(entry_q[k].valid);
        end
    end

    assign dst_writes_s = sb.issue_valid && sb.issue_wr_en
                          && (sb.issue_dst != REG_W'(ZERO_REG)) && !stall_s;

    // Next state: flush beats freeze beats normal advance; a stall inserts a bubble.
    always_comb begin
        entry_d = entry_q;
        if (sb.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_d[k].valid = 1'b0;
            end
        end else if (sb.freeze) begin
            entry_d = entry_q;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                entry_d[k] = entry_q[k-1];
            end
            entry_d[0].valid = dst_writes_s;
            entry_d[0].dst   = REG_W_MAX'(sb.issue_dst);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign sb.hazard        = hazard_s;
    assign sb.match_stage   = match_s;
    assign sb.stall         = stall_s;
    assign sb.pending_count = count_s;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of the default scoreboard plus a seeded stimulus run of a
// REG_W=6/DEPTH=5/NUM_SRC=3 instance against a small behavioural model.
module tb_hazard_scoreboard;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_W(5), .DEPTH(3), .NUM_SRC(2)) ifa ();
    hazard_scoreboard_if #(.REG_W(6), .DEPTH(5), .NUM_SRC(3)) ifb ();

    hazard_scoreboard #(.REG_W(5), .DEPTH(3), .NUM_SRC(2), .ZERO_REG(31)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .sb    (ifa)
    );

    hazard_scoreboard #(.REG_W(6), .DEPTH(5), .NUM_SRC(3), .ZERO_REG(63)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .sb    (ifb)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.issue_valid = 1'b0;
        ifa.issue_wr_en = 1'b0;
        ifa.issue_dst   = 5'd0;
        ifa.src_addr    = '0;
        ifa.src_used    = 2'b00;
        ifa.freeze      = 1'b0;
        ifa.flush       = 1'b0;
    endtask

    task automatic issue_a(input logic [4:0] dst);
        idle_a();
        ifa.issue_valid = 1'b1;
        ifa.issue_wr_en = 1'b1;
        ifa.issue_dst   = dst;
    endtask

    task automatic read_a(input logic [4:0] s0, input logic u0, input logic [4:0] s1, input logic u1);
        idle_a();
        ifa.issue_valid = 1'b1;
        ifa.src_addr[0] = s0;
        ifa.src_used[0] = u0;
        ifa.src_addr[1] = s1;
        ifa.src_used[1] = u1;
    endtask

    task automatic flush_a();
        idle_a();
        ifa.flush = 1'b1;
        step();
        idle_a();
    endtask

    function automatic logic [5:0] pick_b();
        return ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
    endfunction

    logic       mv [5];
    logic [5:0] md [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] b_dst, b_src [3];
        logic       b_iv, b_wr, b_fl, b_fz, b_rst, es, eh, live;
        logic [2:0] em;
        logic [3:0] ecnt;
        logic [2:0] b_used;

        idle_a();
        ifb.issue_valid = 1'b0;
        ifb.issue_wr_en = 1'b0;
        ifb.issue_dst   = 6'd0;
        ifb.src_addr    = '0;
        ifb.src_used    = 3'b000;
        ifb.freeze      = 1'b0;
        ifb.flush       = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check_val("reset_pending", 32'(ifa.pending_count), 32'd0);
        check_val("reset_stall",   32'(ifa.stall),         32'd0);
        check_val("reset_hazard",  32'(ifa.hazard),        32'd0);
        check_val("reset_match",   32'(ifa.match_stage),   32'd0);

        // Writer to r3, then a reader of r3 walks the writer down the pipe.
        issue_a(5'd3);
        #1;
        check_val("w3_no_self_stall", 32'(ifa.stall), 32'd0);
        step();
        read_a(5'd3, 1'b1, 5'd0, 1'b0);
        #1;
        check_val("raw_hazard0", 32'(ifa.hazard), 32'd1);
        check_val("raw_match0",  32'(ifa.match_stage[0]), 32'd0);
        check_val("raw_stall",   32'(ifa.stall), 32'd1);
        step();
        #1;
        check_val("raw_match1", 32'(ifa.match_stage[0]), 32'd1);
        step();
        #1;
        check_val("raw_match2", 32'(ifa.match_stage[0]), 32'd2);
        check_val("raw_pend2",  32'(ifa.pending_count), 32'd1);
        step();
        #1;
        check_val("raw_stall_clear", 32'(ifa.stall), 32'd0);
        check_val("raw_pend_clear",  32'(ifa.pending_count), 32'd0);

        // Zero register neither records nor matches.
        issue_a(5'd31);
        step();
        read_a(5'd31, 1'b1, 5'd31, 1'b1);
        #1;
        check_val("zero_hazard", 32'(ifa.hazard), 32'd0);
        check_val("zero_pend",   32'(ifa.pending_count), 32'd0);

        // Decode does not match its own destination.
        flush_a();
        issue_a(5'd9);
        ifa.src_addr[0] = 5'd9;
        ifa.src_used[0] = 1'b1;
        #1;
        check_val("self_dst", 32'(ifa.hazard), 32'd0);

        // Two writers of r5: youngest wins, unused port stays quiet.
        flush_a();
        issue_a(5'd5);
        step();
        issue_a(5'd5);
        step();
        read_a(5'd5, 1'b1, 5'd5, 1'b0);
        #1;
        check_val("dup_hazard0", 32'(ifa.hazard[0]), 32'd1);
        check_val("dup_match0",  32'(ifa.match_stage[0]), 32'd0);
        check_val("dup_hazard1_unused", 32'(ifa.hazard[1]), 32'd0);
        check_val("dup_match1_unused",  32'(ifa.match_stage[1]), 32'd0);
        check_val("dup_pend", 32'(ifa.pending_count), 32'd2);
        ifa.src_used[1] = 1'b1;
        #1;
        check_val("dup_hazard_both", 32'(ifa.hazard), 32'd3);

        // Fill, freeze (new issue ignored), then flush beats freeze and issue.
        flush_a();
        issue_a(5'd1);
        step();
        issue_a(5'd2);
        step();
        issue_a(5'd4);
        step();
        idle_a();
        #1;
        check_val("fill_pend", 32'(ifa.pending_count), 32'd3);
        for (int c = 0; c < 4; c++) begin
            issue_a(5'd10);
            ifa.freeze = 1'b1;
            step();
            #1;
            check_val("freeze_pend", 32'(ifa.pending_count), 32'd3);
        end
        read_a(5'd1, 1'b1, 5'd4, 1'b1);
        ifa.freeze = 1'b1;
        #1;
        check_val("freeze_match_old",   32'(ifa.match_stage[0]), 32'd2);
        check_val("freeze_match_young", 32'(ifa.match_stage[1]), 32'd0);
        issue_a(5'd6);
        ifa.freeze = 1'b1;
        ifa.flush  = 1'b1;
        step();
        idle_a();
        #1;
        check_val("flush_pend", 32'(ifa.pending_count), 32'd0);

        // Reset in the middle of a stall.
        issue_a(5'd7);
        step();
        read_a(5'd7, 1'b1, 5'd0, 1'b0);
        #1;
        check_val("pre_reset_stall", 32'(ifa.stall), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_val("post_reset_hazard", 32'(ifa.hazard), 32'd0);
        check_val("post_reset_stall",  32'(ifa.stall), 32'd0);
        check_val("post_reset_match",  32'(ifa.match_stage), 32'd0);
        check_val("post_reset_pend",   32'(ifa.pending_count), 32'd0);
        idle_a();

        // Wide instance against a behavioural model.
        for (int k = 0; k < 5; k++) begin
            mv[k] = 1'b0;
            md[k] = 6'd0;
        end
        for (int c = 0; c < 400; c++) begin
            step();
            b_rst  = ($urandom_range(0, 49) == 0);
            b_fl   = ($urandom_range(0, 11) == 0);
            b_fz   = ($urandom_range(0, 4) == 0);
            b_iv   = ($urandom_range(0, 3) != 0);
            b_wr   = ($urandom_range(0, 3) != 0);
            b_dst  = pick_b();
            b_used = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                b_src[i] = pick_b();
                ifb.src_addr[i] = b_src[i];
            end
            ifb.issue_valid = b_iv;
            ifb.issue_wr_en = b_wr;
            ifb.issue_dst   = b_dst;
            ifb.src_used    = b_used;
            ifb.flush       = b_fl;
            ifb.freeze      = b_fz;
            reset           = b_rst;
            #1;
            es = 1'b0;
            for (int i = 0; i < 3; i++) begin
                eh   = 1'b0;
                em   = 3'd0;
                live = b_iv && b_used[i] && (b_src[i] != 6'd63);
                for (int k = 4; k >= 0; k--) begin
                    if (live && mv[k] && (md[k] == b_src[i])) begin
                        eh = 1'b1;
                        em = 3'(k);
                    end
                end
                check_val("b_hazard", 32'(ifb.hazard[i]), 32'(eh));
                check_val("b_match",  32'(ifb.match_stage[i]), 32'(em));
                es = es | eh;
            end
            check_val("b_stall", 32'(ifb.stall), 32'(es));
            ecnt = 4'd0;
            for (int k = 0; k < 5; k++) begin
                ecnt = ecnt + 4'(mv[k]);
            end
            check_val("b_pend", 32'(ifb.pending_count), 32'(ecnt));
            if (b_rst) begin
                for (int k = 0; k < 5; k++) begin
                    mv[k] = 1'b0;
                    md[k] = 6'd0;
                end
            end else if (b_fl) begin
                for (int k = 0; k < 5; k++) begin
                    mv[k] = 1'b0;
                end
            end else if (!b_fz) begin
                for (int k = 4; k >= 1; k--) begin
                    mv[k] = mv[k-1];
                    md[k] = md[k-1];
                end
                mv[0] = b_iv && b_wr && (b_dst != 6'd63) && !es;
                md[0] = b_dst;
            end
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_W, default 5: register-address width.
REQ-002 Parameter DEPTH, default 3: number of in-flight writer stages tracked (DEPTH >= 1).
REQ-003 Parameter NUM_SRC, default 2: number of source-register ports checked each cycle.
REQ-004 Parameter ZERO_REG, default 31: hard-wired zero register, which never creates or matches a dependency.
REQ-005 The block SHALL have one clock, clk, and a synchronous active-high reset, reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous, active-high; clears all tracking state.
REQ-008 issue_valid  input  1  an instruction is presented at decode this cycle.
REQ-009 issue_wr_en  input  1  the presented instruction writes a register.
REQ-010 issue_dst  input  REG_W  destination register of the presented instruction.
REQ-011 src_addr  input  NUM_SRC x REG_W  source register addresses of the presented instruction.
REQ-012 src_used  input  NUM_SRC  per-port flag: the source is actually read.
REQ-013 freeze  input  1  external pipeline hold; scoreboard state holds.
REQ-014 flush  input  1  discard all in-flight writers.
REQ-015 hazard  output  NUM_SRC  per-port dependency on a pending writer.
REQ-016 match_stage  output  NUM_SRC x clog2(DEPTH)  youngest matching stage per port; 0 when there is no hazard.
REQ-017 stall  output  1  OR of hazard, qualified by issue_valid.
REQ-018 pending_count  output  clog2(DEPTH+1)  number of valid tracked entries.

Function
REQ-019 State SHALL be a DEPTH-entry shift register of {valid, dst}; entry 0 is youngest.
REQ-020 hazard[i] SHALL be combinational: issue_valid && src_used[i] && src_addr[i] != ZERO_REG && there exists k with valid[k] && dst[k] == src_addr[i].
REQ-021 match_stage[i] SHALL be the lowest k satisfying REQ-020.
REQ-022 stall SHALL be the OR of hazard[*]; it SHALL NOT be registered (0-cycle latency).
REQ-023 On a clock edge with no reset, no flush and no freeze:
- entries k >= 1 SHALL take the value of entry k-1;
- entry 0 SHALL take valid = issue_valid && issue_wr_en && issue_dst != ZERO_REG && !stall, and dst = issue_dst.
REQ-024 When stall is high, a bubble (valid = 0) SHALL enter entry 0 while older entries still advance, so each hazard resolves in at most DEPTH cycles.
REQ-025 freeze high (and flush low) SHALL hold all entries unchanged; outputs stay combinationally live.
REQ-026 flush high SHALL clear every valid bit on that edge; flush has priority over freeze and over a new issue.
REQ-027 An entry shifted out of stage DEPTH-1 SHALL be discarded; it is treated as retired to the register file.
REQ-028 Multiple entries with the same dst SHALL be legal; match_stage reports the youngest.
REQ-029 The instruction in decode SHALL NOT match against its own issue_dst in the same cycle.
REQ-030 pending_count SHALL equal the popcount of valid[] in the current state.

Reset
REQ-031 On reset, all valid bits SHALL be 0 and all dst fields SHALL be 0; hazard, match_stage, stall and pending_count SHALL read 0 the cycle after.
REQ-032 Reset SHALL have priority over flush, freeze and issue.

Structure
REQ-033 A shared package hazard_pkg SHALL hold the REG_W and ZERO_REG defaults and the typedef sb_entry_t {valid, dst}.
REQ-034 A parameterised sub-module reg_addr_compare (REG_W-wide equality, with valid qualification) SHALL be instantiated DEPTH x NUM_SRC times.
REQ-035 The priority encoder for match_stage SHALL be local to hazard_scoreboard.

Verification
REQ-036 Reset, then issue dst=3 and, next cycle, src_addr[0]=3 with src_used[0]=1 -> hazard[0]=1, match_stage[0]=0, stall=1; stall clears after DEPTH=3 cycles.
REQ-037 Issue dst=31 with wr_en=1, then read src=31 -> no hazard, pending_count stays 0.
REQ-038 Issue dst=5, then dst=5 again; read 5 -> match_stage=0 (youngest); with src_used[1]=0 and src_addr[1]=5 -> hazard[1]=0.
REQ-039 Fill 3 entries (dst=1,2,4), assert freeze for 4 cycles -> pending_count=3 is held; then flush with freeze high -> pending_count=0 next cycle.
REQ-040 Assert reset mid-stall (pending dst=7) -> next cycle all outputs 0, and src=7 does not hazard.
REQ-041 Randomised run against a reference model for REG_W=6, DEPTH=5, NUM_SRC=3, including simultaneous flush/freeze/issue.
